remote_comm: RTL and testbench



---
 rtl/remote_comm_pkg.sv | 19 +
 rtl/remote_comm_uart.sv | 130 +++++++++++++
 rtl/remote_comm.sv | 80 ++++++++
 tb/tb_remote_comm.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_comm_pkg.sv
// Shared types and defaults for the remote_comm host-side command/response link.
package remote_comm_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } cmd_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART: independent transmitter (trmt/tx_done) and mid-bit sampling receiver.
module remote_comm_uart
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  logic             tx_busy;
  logic [8:0]       tx_shift;
  logic [CNT_W-1:0] tx_baud;
  logic [3:0]       tx_bit;

  rx_state_e        rx_state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] rx_baud;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;

  // Transmitter: start bit driven on accept, then 8 data bits and stop from tx_shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_busy  <= 1'b1;
          tx       <= 1'b0;
          tx_shift <= {1'b1, tx_data};
          tx_baud  <= '0;
          tx_bit   <= '0;
        end
      end else if (tx_baud == CNT_W'(BAUD_DIV - 1)) begin
        tx_baud <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + CNT_W'(1);
      end
    end
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: re-check start at mid-bit to reject glitches, then sample each bit mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_baud  <= '0;
          end
        end
        RX_START: begin
          if (rx_baud == CNT_W'(BAUD_DIV / 2 - 1)) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_baud == CNT_W'(BAUD_DIV - 1)) begin
            rx_baud  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_data  <= {rx_sync, rx_shift[7:1]};
              rx_rdy   <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            rx_baud <= rx_baud + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Host-side link to the robot: sends 16-bit commands as two UART bytes, reports received bytes.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  cmd_state_e state;
  logic [7:0] low_byte;
  logic       trmt_c;
  logic [7:0] tx_data_c;
  logic       tx_done;

  // Launch the high byte straight from cmd so its start bit follows snd_cmd by one cycle.
  always_comb begin
    trmt_c    = 1'b0;
    tx_data_c = low_byte;
    case (state)
      IDLE: begin
        trmt_c    = snd_cmd;
        tx_data_c = cmd[15:8];
      end
      SEND_HI: trmt_c = tx_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      low_byte <= '0;
      cmd_snt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snd_cmd) begin
            low_byte <= cmd[7:0];
            cmd_snt  <= 1'b0;
            state    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (tx_done) state <= SEND_LO;
        end
        SEND_LO: begin
          if (tx_done) begin
            cmd_snt <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  remote_comm_uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt_c),
    .tx_data(tx_data_c),
    .tx_done(tx_done),
    .tx     (TX),
    .rx     (RX),
    .rx_data(resp),
    .rx_rdy (resp_rdy)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: frame-level model of TX, cmd_snt and resp behaviour.
module tb_remote_comm;

  localparam int unsigned BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  assign RX = loop_en ? TX : rx_drv;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd),
    .snd_cmd (snd_cmd),
    .cmd_snt (cmd_snt),
    .TX      (TX),
    .RX      (RX),
    .resp    (resp),
    .resp_rdy(resp_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model state: bytes owed on TX, bytes in flight on RX, cmd_snt expectation.
  typedef struct {logic [7:0] b; bit lo;} txf_t;
  typedef struct {logic [7:0] b; int t0;} rxf_t;
  txf_t       txq[$];
  rxf_t       rxq[$];
  logic [7:0] tx_log[$];
  logic [7:0] resp_log[$];
  bit         tx_active = 1'b0;
  int         tx_t0 = 0;
  logic [7:0] tx_byte = '0;
  bit         tx_lo = 1'b0;
  int         tx_last_end = 0;
  int         exp_start = -1;
  int         snt_state = 0;  // 0: must be low, 1: must be high, 2: rising window
  int         snt_deadline = 0;
  logic [7:0] last_resp = '0;
  logic       prev_rdy = 1'b0;
  txf_t       tf;
  rxf_t       rf;
  int         n;
  int         bitn;
  logic       expb;

  function automatic bit model_idle();
    return txq.size() == 0 && !tx_active && snt_state != 2;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tx", TX, 1);
      chk("rst_cmd_snt", cmd_snt, 0);
      chk("rst_resp", resp, 0);
      chk("rst_resp_rdy", resp_rdy, 0);
      txq.delete();
      rxq.delete();
      tx_active = 1'b0;
      snt_state = 0;
      last_resp = '0;
      prev_rdy  = 1'b0;
      exp_start = -1;
    end else begin
      if (!tx_active) begin
        if (cyc == exp_start) chk("tx_start_latency", TX, 0);
        if (TX == 1'b0) begin
          if (txq.size() == 0) begin
            chk("tx_spurious_start", TX, 1);
          end else begin
            tf = txq.pop_front();
            tx_active = 1'b1;
            tx_t0 = cyc;
            tx_byte = tf.b;
            tx_lo = tf.lo;
            if (tf.lo) chk("tx_inter_frame_gap", 32'(cyc - tx_last_end <= 1), 1);
            if (loop_en) rxq.push_back('{b: tf.b, t0: cyc});
            tx_log.push_back(tf.b);
          end
        end
      end
      if (tx_active) begin
        n = cyc - tx_t0;
        bitn = n / int'(BD);
        if (bitn == 0) expb = 1'b0;
        else if (bitn >= 9) expb = 1'b1;
        else expb = tx_byte[bitn-1];
        chk("tx_bit", TX, expb);
        if (n == 10 * int'(BD) - 1) begin
          tx_active = 1'b0;
          tx_last_end = cyc + 1;
          if (tx_lo) begin
            snt_state = 2;
            snt_deadline = cyc + 3;
          end
        end
      end

      if (snt_state == 2 && cyc >= snt_deadline) snt_state = 1;
      if (snt_state == 0) chk("cmd_snt_low", cmd_snt, 0);
      else if (snt_state == 1) chk("cmd_snt_high", cmd_snt, 1);

      if (resp_rdy) begin
        chk("resp_rdy_one_cycle", prev_rdy, 0);
        if (rxq.size() == 0) begin
          chk("resp_rdy_spurious", resp_rdy, 0);
        end else begin
          rf = rxq.pop_front();
          chk("resp_value", resp, rf.b);
          chk("resp_rdy_timing",
              32'((cyc - rf.t0 >= 8 * int'(BD) + int'(BD) / 2) && (cyc - rf.t0 <= 10 * int'(BD))), 1);
          last_resp = rf.b;
          resp_log.push_back(resp);
        end
      end else begin
        chk("resp_hold", resp, last_resp);
      end
      prev_rdy = resp_rdy;

      if (snd_cmd && model_idle()) begin
        txq.push_back('{b: cmd[15:8], lo: 1'b0});
        txq.push_back('{b: cmd[7:0], lo: 1'b1});
        snt_state = 0;
        exp_start = cyc + 1;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c);
    cmd = c;
    snd_cmd = 1'b1;
    tick(1);
    snd_cmd = 1'b0;
    cmd = 16'($urandom);
  endtask

  int last_wait = 0;

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (cmd_snt !== 1'b1 && k < 25 * int'(BD)) begin
      tick(1);
      k++;
    end
    chk({name, "_done"}, 32'(k < 25 * int'(BD)), 1);
    last_wait = k;
    tick(3);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rxq.push_back('{b: b, t0: cyc});
    rx_drv = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(BD);
    end
    rx_drv = 1'b1;
    tick(BD);
  endtask

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: run did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    logic [7:0]  b;
    int          sz;

    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Quiet line after reset.
    tick(1000);
    chk("idle_tx", TX, 1);
    chk("idle_cmd_snt", cmd_snt, 0);
    chk("idle_resp_rdy", resp_rdy, 0);
    chk("idle_resp", resp, 8'h00);

    // All-zero command.
    send(16'h0000);
    wait_done("cmd0000");
    chk("cmd0000_latency_lo", 32'(last_wait >= 20 * int'(BD)), 1);
    chk("cmd0000_latency_hi", 32'(last_wait <= 20 * int'(BD) + 3), 1);
    chk("cmd0000_nbytes", tx_log.size(), 2);
    chk("cmd0000_hi", tx_log[0], 8'h00);
    chk("cmd0000_lo", tx_log[1], 8'h00);
    tick(50);
    chk("cmd_snt_held", cmd_snt, 1);
    tx_log.delete();

    // A53C with requests issued during both frames.
    send(16'hA53C);
    tick(5 * BD);
    send(16'hFFFF);
    tick(8 * BD);
    send(16'h1111);
    wait_done("cmdA53C");
    chk("cmdA53C_nbytes", tx_log.size(), 2);
    chk("cmdA53C_hi", tx_log[0], 8'hA5);
    chk("cmdA53C_lo", tx_log[1], 8'h3C);
    tx_log.delete();

    // Response byte from the robot.
    drive_rx(8'h5A);
    tick(BD);
    chk("resp5A_now", resp, 8'h5A);
    chk("resp5A_count", resp_log.size(), 1);
    tick(1000);
    chk("resp5A_held", resp, 8'h5A);
    chk("resp_rdy_quiet", resp_rdy, 0);

    // Short low glitch must not start a frame.
    rx_drv = 1'b0;
    tick(BD / 4);
    rx_drv = 1'b1;
    tick(3 * BD);
    chk("glitch_no_byte", resp_log.size(), 1);
    chk("glitch_resp", resp, 8'h5A);

    // Loopback of TX into RX.
    loop_en = 1'b1;
    send(16'h1234);
    wait_done("loop1234");
    tick(2 * BD);
    loop_en = 1'b0;
    chk("loop_count", resp_log.size(), 3);
    chk("loop_first", resp_log[1], 8'h12);
    chk("loop_second", resp_log[2], 8'h34);
    tx_log.delete();

    // Random commands with concurrent random responses and stray requests.
    for (int it = 0; it < 6; it++) begin
      c = 16'($urandom);
      b = 8'($urandom);
      fork
        begin
          send(c);
          tick($urandom_range(2, 18 * BD));
          send(16'($urandom));
          wait_done("rand_cmd");
        end
        begin
          tick($urandom_range(0, 6 * BD));
          drive_rx(b);
        end
      join
      sz = tx_log.size();
      chk("rand_nbytes", sz, 2);
      if (sz >= 2) begin
        chk("rand_hi", tx_log[sz-2], c[15:8]);
        chk("rand_lo", tx_log[sz-1], c[7:0]);
      end
      chk("rand_resp", resp, b);
      tx_log.delete();
      tick($urandom_range(1, 50));
    end

    // Reset in the middle of the first frame.
    send(16'h00FF);
    tick(BD / 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", TX, 1);
    chk("rst_mid_cmd_snt", cmd_snt, 0);
    chk("rst_mid_resp", resp, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tx_log.delete();
    tick(5);
    send(16'hBEEF);
    wait_done("cmdBEEF");
    chk("cmdBEEF_nbytes", tx_log.size(), 2);
    chk("cmdBEEF_hi", tx_log[0], 8'hBE);
    chk("cmdBEEF_lo", tx_log[1], 8'hEF);

    // Reset while cmd_snt is high.
    chk("pre_rst_cmd_snt", cmd_snt, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_idle_cmd_snt", cmd_snt, 0);
    tick(2);
    rst_n = 1'b1;

    tick(10);
    chk("queues_drained", txq.size() + rxq.size(), 0);
    chk("tx_not_active", tx_active, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
